// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: the funct3 branch
// encodings and a helper that tells legal from reserved encodings.
package branch_resolve_unit_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_RSV2 = 3'b010,
    BR_RSV3 = 3'b011,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_type_e;

  // Encodings 010 and 011 are reserved; every other funct3 is a real branch.
  function automatic logic isLegalBranch(input logic [2:0] branchType);
    return (branchType[2:1] != 2'b01);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// Purely combinational branch condition evaluator. Produces the raw
// taken condition and an illegal flag for reserved encodings; both are
// forced low for pass-through (non-branch) requests.
module branch_cond
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_branch,
  input  logic [2:0]      branch_type,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            cond,
  output logic            illegal
);

  logic w_eq;
  logic w_lt;
  logic w_ltu;
  logic w_legal;

  assign w_eq    = (a == b);
  assign w_lt    = ($signed(a) < $signed(b));
  assign w_ltu   = (a < b);
  assign w_legal = isLegalBranch(branch_type);

  // Select the comparison that matches the funct3 encoding.
  always_comb begin
    cond = 1'b0;
    if (is_branch) begin
      case (branch_type)
        BR_BEQ:  cond = w_eq;
        BR_BNE:  cond = ~w_eq;
        BR_BLT:  cond = w_lt;
        BR_BGE:  cond = ~w_lt;
        BR_BLTU: cond = w_ltu;
        BR_BGEU: cond = ~w_ltu;
        default: cond = 1'b0;
      endcase
    end
  end

  assign illegal = is_branch & ~w_legal;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates a conditional branch, registers the
// outcome in a single output stage with a valid/ready handshake, and
// keeps saturating statistics counters of branches and mispredictions.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_branch,
  input  logic [2:0]       branch_type,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  target,
  input  logic             pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             illegal,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic             r_outValid;
  logic             r_taken;
  logic             r_mispredict;
  logic             r_illegal;
  logic [XLEN-1:0]  r_redirectPc;
  logic [CNT_W-1:0] r_branchCnt;
  logic [CNT_W-1:0] r_mispredCnt;

  logic             w_cond;
  logic             w_illegal;
  logic             w_accept;
  logic             w_mispredict;
  logic             w_countBranch;
  logic [XLEN-1:0]  w_pcPlus4;
  logic [XLEN-1:0]  w_redirect;

  branch_cond #(
    .XLEN(XLEN)
  ) u_branch_cond (
    .is_branch  (is_branch),
    .branch_type(branch_type),
    .a          (a),
    .b          (b),
    .cond       (w_cond),
    .illegal    (w_illegal)
  );

  // The slot is free when empty or being drained; reset and flush both
  // refuse new work so nothing is accepted (or counted) in those cycles.
  assign in_ready      = rst_n & ~flush & (~r_outValid | out_ready);
  assign w_accept      = in_valid & in_ready;

  assign w_pcPlus4     = pc + {{(XLEN-3){1'b0}}, 3'b100};
  assign w_redirect    = w_cond ? target : w_pcPlus4;
  assign w_mispredict  = is_branch & ~w_illegal & (w_cond ^ pred_taken);
  assign w_countBranch = is_branch & ~w_illegal;

  // Output register: reset beats flush, flush beats acceptance, and an
  // accept during a drain simply overwrites the slot with no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid   <= 1'b0;
      r_taken      <= 1'b0;
      r_mispredict <= 1'b0;
      r_illegal    <= 1'b0;
      r_redirectPc <= '0;
    end else if (flush) begin
      r_outValid   <= 1'b0;
    end else if (w_accept) begin
      r_outValid   <= 1'b1;
      r_taken      <= w_cond;
      r_mispredict <= w_mispredict;
      r_illegal    <= w_illegal;
      r_redirectPc <= w_redirect;
    end else if (out_ready) begin
      r_outValid   <= 1'b0;
    end
  end

  // Statistics counters bump at acceptance and stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_branchCnt  <= '0;
      r_mispredCnt <= '0;
    end else if (w_accept) begin
      if (w_countBranch && (r_branchCnt != {CNT_W{1'b1}}))
        r_branchCnt <= r_branchCnt + 1'b1;
      if (w_mispredict && (r_mispredCnt != {CNT_W{1'b1}}))
        r_mispredCnt <= r_mispredCnt + 1'b1;
    end
  end

  assign out_valid   = r_outValid;
  assign taken       = r_taken;
  assign mispredict  = r_mispredict;
  assign illegal     = r_illegal;
  assign redirect_pc = r_redirectPc;
  assign branch_cnt  = r_branchCnt;
  assign mispred_cnt = r_mispredCnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: a table of directed
// vectors with hand-computed results, followed by hand-written sequences
// for stall, flush, drain, mid-stream reset and counter saturation.
module tb_branch_resolve_unit;

  typedef struct {
    logic        isBranch;
    logic [2:0]  bType;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] target;
    logic        predTaken;
    logic        expTaken;
    logic        expMisp;
    logic        expIllegal;
    logic [31:0] expRedirect;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, is_branch, pred_taken, flush;
  logic        out_valid, out_ready, taken, mispredict, illegal;
  logic [2:0]  branch_type;
  logic [31:0] a, b, pc, target, redirect_pc;
  logic [15:0] branch_cnt, mispred_cnt;

  logic        s_in_valid, s_in_ready, s_is_branch, s_pred_taken, s_flush;
  logic        s_out_valid, s_out_ready, s_taken, s_mispredict, s_illegal;
  logic [2:0]  s_branch_type;
  logic [31:0] s_a, s_b, s_pc, s_target, s_redirect_pc;
  logic [3:0]  s_branch_cnt, s_mispred_cnt;

  int total = 0;
  int bad   = 0;
  int expBr = 0;
  int expMp = 0;

  vec_t vecs[13];
  vec_t vA, vB, vC;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .is_branch(is_branch), .branch_type(branch_type), .a(a), .b(b),
    .pc(pc), .target(target), .pred_taken(pred_taken), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .illegal(illegal),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_resolve_unit #(.XLEN(32), .CNT_W(4)) dutSat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .is_branch(s_is_branch), .branch_type(s_branch_type), .a(s_a), .b(s_b),
    .pc(s_pc), .target(s_target), .pred_taken(s_pred_taken), .flush(s_flush),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .taken(s_taken),
    .mispredict(s_mispredict), .redirect_pc(s_redirect_pc), .illegal(s_illegal),
    .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt)
  );

  function automatic vec_t mkVec(logic isBr, logic [2:0] t, logic [31:0] va,
                                 logic [31:0] vb, logic [31:0] vpc, logic [31:0] vt,
                                 logic pt, logic eT, logic eM, logic eI,
                                 logic [31:0] eR);
    vec_t v;
    v.isBranch = isBr; v.bType = t; v.a = va; v.b = vb; v.pc = vpc;
    v.target = vt; v.predTaken = pt; v.expTaken = eT; v.expMisp = eM;
    v.expIllegal = eI; v.expRedirect = eR;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    is_branch   = v.isBranch;
    branch_type = v.bType;
    a           = v.a;
    b           = v.b;
    pc          = v.pc;
    target      = v.target;
    pred_taken  = v.predTaken;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResult(input string tag, input vec_t v);
    checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, ".taken"}, 64'(taken), 64'(v.expTaken));
    checkOutput({tag, ".mispredict"}, 64'(mispredict), 64'(v.expMisp));
    checkOutput({tag, ".illegal"}, 64'(illegal), 64'(v.expIllegal));
    checkOutput({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(v.expRedirect));
  endtask

  task automatic checkCounts(input string tag);
    checkOutput({tag, ".branch_cnt"}, 64'(branch_cnt), 64'(expBr));
    checkOutput({tag, ".mispred_cnt"}, 64'(mispred_cnt), 64'(expMp));
  endtask

  initial begin
    vecs[0]  = mkVec(1, 3'b100, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h200, 0, 1, 1, 0, 32'h200);
    vecs[1]  = mkVec(1, 3'b111, 32'hFFFFFFFF, 32'h1, 32'h104, 32'h300, 1, 1, 0, 0, 32'h300);
    vecs[2]  = mkVec(1, 3'b110, 32'hFFFFFFFF, 32'h1, 32'h108, 32'h400, 1, 0, 1, 0, 32'h10C);
    vecs[3]  = mkVec(1, 3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h10C, 32'h500, 0, 0, 0, 0, 32'h110);
    vecs[4]  = mkVec(1, 3'b000, 32'h5, 32'h5, 32'h110, 32'h600, 0, 1, 1, 0, 32'h600);
    vecs[5]  = mkVec(1, 3'b001, 32'h5, 32'h5, 32'h114, 32'h700, 0, 0, 0, 0, 32'h118);
    vecs[6]  = mkVec(1, 3'b101, 32'h7FFFFFFF, 32'h80000000, 32'h118, 32'h800, 1, 1, 0, 0, 32'h800);
    vecs[7]  = mkVec(1, 3'b110, 32'h1, 32'hFFFFFFFF, 32'h11C, 32'h900, 0, 1, 1, 0, 32'h900);
    vecs[8]  = mkVec(1, 3'b010, 32'h0, 32'h0, 32'h120, 32'hA00, 1, 0, 0, 1, 32'h124);
    vecs[9]  = mkVec(1, 3'b011, 32'h9, 32'h9, 32'h124, 32'hB00, 0, 0, 0, 1, 32'h128);
    vecs[10] = mkVec(0, 3'b000, 32'h5, 32'h5, 32'hFFFFFFFC, 32'hC00, 1, 0, 0, 0, 32'h0);
    vecs[11] = mkVec(1, 3'b001, 32'h1, 32'h2, 32'h128, 32'hD00, 1, 1, 0, 0, 32'hD00);
    vecs[12] = mkVec(1, 3'b100, 32'h1, 32'hFFFFFFFF, 32'h12C, 32'hE00, 1, 0, 1, 0, 32'h130);

    vA = mkVec(1, 3'b100, 32'h1, 32'h2, 32'h400, 32'h800, 0, 1, 1, 0, 32'h800);
    vB = mkVec(1, 3'b111, 32'h1, 32'h2, 32'h500, 32'h900, 0, 0, 0, 0, 32'h504);
    vC = mkVec(1, 3'b000, 32'h3, 32'h3, 32'h600, 32'hA00, 0, 1, 1, 0, 32'hA00);

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    applyStimulus(vecs[0]);
    s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b1; s_is_branch = 1'b1;
    s_branch_type = 3'b000; s_a = 32'h7; s_b = 32'h7; s_pc = 32'h40;
    s_target = 32'h80; s_pred_taken = 1'b0;

    // Reset state
    step(); step();
    checkOutput("reset.out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset.in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset.taken", 64'(taken), 64'd0);
    checkOutput("reset.redirect_pc", 64'(redirect_pc), 64'd0);
    checkCounts("reset");
    checkOutput("reset.sat_branch_cnt", 64'(s_branch_cnt), 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("idle.in_ready", 64'(in_ready), 64'd1);

    // Table-driven vectors, one accepted per cycle
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      in_valid = 1'b1;
      step();
      if (vecs[i].isBranch && !vecs[i].expIllegal) expBr++;
      if (vecs[i].expMisp) expMp++;
      checkResult($sformatf("vec%0d", i), vecs[i]);
      checkCounts($sformatf("vec%0d", i));
    end

    // Stall: hold the result while the consumer is not ready
    applyStimulus(vA);
    step();
    expBr++; expMp++;
    checkResult("stallA", vA);
    applyStimulus(vB);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("stall%0d.in_ready", i), 64'(in_ready), 64'd0);
      step();
      checkResult($sformatf("stall%0d", i), vA);
      checkCounts($sformatf("stall%0d", i));
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release.in_ready", 64'(in_ready), 64'd1);
    step();
    expBr++;
    checkResult("noBubbleB", vB);
    checkCounts("noBubbleB");

    // Flush with a valid result held and a new request offered
    applyStimulus(vC);
    flush = 1'b1;
    #1;
    checkOutput("flush.in_ready", 64'(in_ready), 64'd0);
    step();
    checkOutput("flush.out_valid", 64'(out_valid), 64'd0);
    checkCounts("flush");
    flush = 1'b0;

    // Accept then drain with no new request
    step();
    expBr++; expMp++;
    checkResult("afterFlushC", vC);
    checkCounts("afterFlushC");
    in_valid = 1'b0;
    step();
    checkOutput("drain.out_valid", 64'(out_valid), 64'd0);

    // Reset in the middle of a stream
    applyStimulus(vA);
    in_valid = 1'b1;
    step();
    expBr++; expMp++;
    checkCounts("preReset");
    rst_n = 1'b0;
    step();
    expBr = 0; expMp = 0;
    checkOutput("midReset.out_valid", 64'(out_valid), 64'd0);
    checkOutput("midReset.taken", 64'(taken), 64'd0);
    checkOutput("midReset.mispredict", 64'(mispredict), 64'd0);
    checkOutput("midReset.redirect_pc", 64'(redirect_pc), 64'd0);
    checkOutput("midReset.in_ready", 64'(in_ready), 64'd0);
    checkCounts("midReset");
    rst_n = 1'b1;
    in_valid = 1'b0;

    // Saturation on the 4-bit counter instance
    s_in_valid = 1'b1;
    for (int i = 0; i < 15; i++) step();
    checkOutput("sat15.branch_cnt", 64'(s_branch_cnt), 64'd15);
    checkOutput("sat15.mispred_cnt", 64'(s_mispred_cnt), 64'd15);
    for (int i = 0; i < 5; i++) step();
    checkOutput("sat20.branch_cnt", 64'(s_branch_cnt), 64'd15);
    checkOutput("sat20.mispred_cnt", 64'(s_mispred_cnt), 64'd15);
    s_in_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
